// File: rtl/fft_framer_pkg.sv
// Shared types and default sizes for the FFT input framer.
package fft_framer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAD  = 2'd2
   } state_t;

   localparam int DEF_DATA_WIDTH = 18;
   localparam int DEF_LEN_WIDTH  = 11;
   localparam int DEF_FFT_SIZE   = 2048;
   localparam int DEF_FIFO_DEPTH = 64;

   // Output index width for the default FFT size
   localparam int IDX_W = $clog2(DEF_FFT_SIZE);

   // Index width for an arbitrary power-of-two size, never below one bit
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through skid FIFO: registered write, combinational head read.
module sync_fifo
   import fft_framer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = idx_width(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  do_wr, do_rd;

   // A read frees a slot in the same cycle, so a full FIFO still takes a write
   // when it is being read.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CNT_FULL);
      rd_data  = mem_q[rd_ptr_q];
      do_rd    = rd_en && !empty;
      do_wr    = wr_en && (!full || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Sample storage; contents are don't-care while empty, so no reset
   always_ff @(posedge CLK) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/fft_in_framer.sv
// Frames a non-stallable burst of M samples into one FFT_SIZE block with
// sop/eop markers and zero padding, absorbing FFT backpressure in a FIFO.
module fft_in_framer
   import fft_framer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FFT_SIZE   = DEF_FFT_SIZE,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  in_start,
   input  logic [LEN_WIDTH-1:0]  frame_len,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fft_ready,
   output logic                  fft_valid,
   output logic [DATA_WIDTH-1:0] fft_data,
   output logic                  fft_sop,
   output logic                  fft_eop,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  err_len,
   output logic                  err_ovf
);

   localparam int IW = idx_width(FFT_SIZE);
   localparam logic [IW-1:0]        IDX_ONE  = IW'(1);
   localparam logic [IW-1:0]        IDX_LAST = IW'(FFT_SIZE - 1);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] in_cnt_q, in_cnt_d;
   logic [IW-1:0]        out_idx_q, out_idx_d;
   logic                 done_q, done_d;
   logic                 err_len_q, err_len_d;
   logic                 err_ovf_q, err_ovf_d;

   logic                  fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  head_vld, xfer, accept, drop, len_ok, last_data;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (fifo_wr),
      .wr_data (data_in),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Output handshake, input acceptance and FIFO control
   always_comb begin
      head_vld   = (state_q == DATA) && !fifo_empty;
      fft_valid  = head_vld || (state_q == PAD);
      fft_data   = head_vld ? fifo_rd_data : '0;
      fft_sop    = fft_valid && (out_idx_q == '0);
      fft_eop    = fft_valid && (out_idx_q == IDX_LAST);
      xfer       = fft_valid && fft_ready;
      accept     = (state_q != IDLE) && in_valid && (in_cnt_q < len_q);
      fifo_wr    = accept;
      fifo_rd    = head_vld && fft_ready;
      drop       = accept && fifo_full && !fifo_rd;
      len_ok     = (frame_len != '0) && (32'(frame_len) <= 32'(FFT_SIZE));
      last_data  = (32'(out_idx_q) == 32'(len_q) - 32'd1);
      busy       = (state_q != IDLE);
      frame_done = done_q;
      err_len    = err_len_q;
      err_ovf    = err_ovf_q;
   end

   // Framing FSM and counters. Dropped samples still count as input, so once
   // every input slot is accounted for and the FIFO has drained, the rest of
   // the block is padded; this keeps the frame exactly FFT_SIZE long.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      in_cnt_d  = accept ? in_cnt_q + LEN_ONE : in_cnt_q;
      out_idx_d = xfer ? out_idx_q + IDX_ONE : out_idx_q;
      done_d    = 1'b0;
      err_len_d = 1'b0;
      err_ovf_d = err_ovf_q || drop;
      case (state_q)
         IDLE: begin
            if (in_start) begin
               if (len_ok) begin
                  state_d   = DATA;
                  len_d     = frame_len;
                  in_cnt_d  = '0;
                  out_idx_d = '0;
               end else begin
                  err_len_d = 1'b1;
               end
            end
         end
         DATA: begin
            err_len_d = in_start;
            if (xfer && fft_eop) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               in_cnt_d  = '0;
               out_idx_d = '0;
            end else if (xfer && last_data) begin
               state_d = PAD;
            end else if (fifo_empty && (in_cnt_q == len_q)) begin
               state_d = PAD;
            end
         end
         PAD: begin
            err_len_d = in_start;
            if (xfer && fft_eop) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               in_cnt_d  = '0;
               out_idx_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_idx_q <= '0;
         done_q    <= 1'b0;
         err_len_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         out_idx_q <= out_idx_d;
         done_q    <= done_d;
         err_len_q <= err_len_d;
         err_ovf_q <= err_ovf_d;
      end
   end

endmodule

// File: tb/tb_fft_in_framer.sv
// Directed bench for fft_in_framer with FFT_SIZE=16, FIFO_DEPTH=4.
module tb_fft_in_framer;

   localparam int DW = 18;
   localparam int LW = 5;
   localparam int N  = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic          in_start;
   logic [LW-1:0] frame_len;
   logic          in_valid;
   logic [DW-1:0] data_in;
   logic          fft_ready;
   logic          fft_valid;
   logic [DW-1:0] fft_data;
   logic          fft_sop, fft_eop, frame_done, busy, err_len, err_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   int mon_en = 0;
   int n_xfer, done_cnt, done_cyc, eop_cyc, err_len_cnt, first_in, first_vld;
   int got_data [32];
   int got_sop  [32];
   int got_eop  [32];
   int exp_data [N];
   int prev_stall = 0;
   int prev_data, prev_sop, prev_eop;

   fft_in_framer #(
      .DATA_WIDTH (DW),
      .FFT_SIZE   (N),
      .FIFO_DEPTH (4),
      .LEN_WIDTH  (LW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .in_start   (in_start),
      .frame_len  (frame_len),
      .in_valid   (in_valid),
      .data_in    (data_in),
      .fft_ready  (fft_ready),
      .fft_valid  (fft_valid),
      .fft_data   (fft_data),
      .fft_sop    (fft_sop),
      .fft_eop    (fft_eop),
      .frame_done (frame_done),
      .busy       (busy),
      .err_len    (err_len),
      .err_ovf    (err_ovf)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Observe on the falling edge: record transfers and verify stall stability
   always @(negedge CLK) begin
      if (mon_en != 0 && RST == 1'b0) begin
         if (in_valid && first_in < 0) first_in = cyc;
         if (fft_valid && first_vld < 0) first_vld = cyc;
         if (prev_stall != 0) begin
            check("hold_valid", longint'(fft_valid), 1);
            check("hold_data", longint'(fft_data), longint'(prev_data));
            check("hold_sop", longint'(fft_sop), longint'(prev_sop));
            check("hold_eop", longint'(fft_eop), longint'(prev_eop));
         end
         prev_stall = (fft_valid && !fft_ready) ? 1 : 0;
         prev_data  = int'(fft_data);
         prev_sop   = int'(fft_sop);
         prev_eop   = int'(fft_eop);
         if (fft_valid && fft_ready) begin
            if (n_xfer < 32) begin
               got_data[n_xfer] = int'(fft_data);
               got_sop[n_xfer]  = int'(fft_sop);
               got_eop[n_xfer]  = int'(fft_eop);
            end
            if (fft_eop) eop_cyc = cyc;
            n_xfer++;
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err_len) err_len_cnt++;
      end else begin
         prev_stall = 0;
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, longint'(fft_valid), 0);
      check({tag, "_data"}, longint'(fft_data), 0);
      check({tag, "_sop"}, longint'(fft_sop), 0);
      check({tag, "_eop"}, longint'(fft_eop), 0);
      check({tag, "_done"}, longint'(frame_done), 0);
      check({tag, "_busy"}, longint'(busy), 0);
      check({tag, "_errlen"}, longint'(err_len), 0);
      check({tag, "_errovf"}, longint'(err_ovf), 0);
   endtask

   // Start a frame and stream nsamp samples 1..nsamp; fft_ready is low for
   // burst cycles st_lo..st_hi, in_start is re-pulsed at burst cycle mid_start,
   // and RST is raised once abort_after transfers have been seen.
   task automatic run_frame(input int len, input int nsamp, input int st_lo,
                            input int st_hi, input int mid_start, input int abort_after);
      n_xfer = 0; done_cnt = 0; done_cyc = -1; eop_cyc = -100;
      err_len_cnt = 0; first_in = -1; first_vld = -1;
      in_start = 1'b1; frame_len = LW'(len); fft_ready = 1'b1; in_valid = 1'b0;
      @(posedge CLK); #1;
      in_start = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         in_valid  = (k <= nsamp);
         data_in   = DW'(k);
         fft_ready = !(k >= st_lo && k <= st_hi);
         in_start  = (k == mid_start);
         frame_len = LW'(5);
         @(posedge CLK); #1;
         if (abort_after > 0 && n_xfer >= abort_after) begin
            #1 RST = 1'b1;
            in_valid = 1'b0; in_start = 1'b0;
            #1;
            return;
         end
         if (k >= nsamp && n_xfer >= N) break;
      end
      in_valid = 1'b0; in_start = 1'b0; fft_ready = 1'b1;
      repeat (3) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_nxfer"}, n_xfer, N);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
         check($sformatf("%s_sop%0d", tag, i), got_sop[i], (i == 0) ? 1 : 0);
         check($sformatf("%s_eop%0d", tag, i), got_eop[i], (i == N - 1) ? 1 : 0);
      end
      check({tag, "_donecnt"}, done_cnt, 1);
      check({tag, "_donelat"}, done_cyc, eop_cyc + 1);
      check({tag, "_busy_end"}, longint'(busy), 0);
   endtask

   task automatic start_only(input string tag, input int len);
      err_len_cnt = 0;
      in_start = 1'b1; frame_len = LW'(len);
      @(posedge CLK); #1;
      in_start = 1'b0;
      check({tag, "_errlen"}, longint'(err_len), 1);
      check({tag, "_busy"}, longint'(busy), 0);
      @(posedge CLK); #1;
      check({tag, "_errlen_off"}, longint'(err_len), 0);
      check({tag, "_busy2"}, longint'(busy), 0);
   endtask

   initial begin
      RST = 1'b1; in_start = 1'b0; frame_len = '0; in_valid = 1'b0;
      data_in = '0; fft_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_zero("reset");
      RST = 1'b0;
      mon_en = 1;
      @(posedge CLK); #1;

      for (int i = 0; i < N; i++) exp_data[i] = (i < 12) ? i + 1 : 0;
      run_frame(12, 12, 0, 0, 0, 0);
      check_frame("nom");
      check("nom_latency", first_vld, first_in + 1);
      check("nom_ovf", longint'(err_ovf), 0);

      run_frame(12, 12, 2, 4, 0, 0);
      check_frame("bp");
      check("bp_ovf", longint'(err_ovf), 0);

      start_only("len0", 0);
      start_only("len17", 17);

      run_frame(12, 12, 0, 0, 6, 0);
      check_frame("mid");
      check("mid_errlen_cnt", err_len_cnt, 1);

      for (int i = 0; i < N; i++) exp_data[i] = i + 1;
      run_frame(16, 17, 0, 0, 0, 0);
      check_frame("full");

      exp_data = '{1, 2, 3, 4, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0, 0, 0};
      run_frame(12, 12, 1, 8, 0, 0);
      check_frame("ovf");
      check("ovf_flag", longint'(err_ovf), 1);
      repeat (3) begin
         @(posedge CLK); #1;
      end
      check("ovf_sticky", longint'(err_ovf), 1);

      run_frame(12, 12, 0, 0, 0, 5);
      check("abort_nxfer", n_xfer, 5);
      check_zero("abort");
      repeat (3) begin
         @(posedge CLK); #1;
      end
      check("abort_nodone", done_cnt, 0);
      RST = 1'b0;
      @(posedge CLK); #1;

      for (int i = 0; i < N; i++) exp_data[i] = (i < 12) ? i + 1 : 0;
      run_frame(12, 12, 0, 0, 0, 0);
      check_frame("post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
